// File: rtl/ps2_ascii_fifo.sv
// PS/2 keyboard front end: synchronised and glitch-filtered line receiver, scancode-set-2
// decoder with shift/caps tracking, and a show-ahead ASCII output FIFO.
module ps2_ascii_fifo #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                ps2_clk,
  input  logic                                ps2_dat,
  output logic [6:0]                          ascii_data,
  output logic                                ascii_valid,
  input  logic                                ascii_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
  output logic                                frame_err,
  output logic                                overflow
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned FltW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic [1:0]      clk_sync_q, dat_sync_q;
  logic            clk_s, dat_s;
  logic            filt_q, filt_flip, fall;
  logic [FltW-1:0] flt_cnt_q;

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];
  // The filtered clock flips on the FILTER_LEN-th consecutive sample that disagrees with it.
  assign filt_flip = (clk_s != filt_q) && (flt_cnt_q == FltW'(FILTER_LEN - 1));
  assign fall      = filt_flip & filt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      flt_cnt_q  <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_dat};
      if (clk_s == filt_q) begin
        flt_cnt_q <= '0;
      end else if (filt_flip) begin
        filt_q    <= clk_s;
        flt_cnt_q <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_q + FltW'(1);
      end
    end
  end

  state_e          state_q;
  logic [2:0]      bitcnt_q;
  logic [7:0]      shreg_q;
  logic            par_q, byte_valid_q, frame_err_q;
  logic [TmoW-1:0] tmo_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      bitcnt_q     <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (state_q != StIdle && !fall && tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
        state_q     <= StIdle;
        tmo_q       <= '0;
        frame_err_q <= 1'b1;
      end else begin
        tmo_q <= (fall || state_q == StIdle) ? '0 : tmo_q + TmoW'(1);
        if (fall) begin
          unique case (state_q)
            StIdle: begin
              if (!dat_s) begin
                state_q  <= StData;
                bitcnt_q <= '0;
              end
            end
            StData: begin
              shreg_q  <= {dat_s, shreg_q[7:1]};
              bitcnt_q <= bitcnt_q + 3'd1;
              if (bitcnt_q == 3'd7) state_q <= StParity;
            end
            StParity: begin
              par_q   <= dat_s;
              state_q <= StStop;
            end
            StStop: begin
              if (dat_s && (^{shreg_q, par_q})) byte_valid_q <= 1'b1;
              else                              frame_err_q  <= 1'b1;
              state_q <= StIdle;
            end
          endcase
        end
      end
    end
  end

  logic       brk_q, ext_q, shift_q, caps_q;
  logic [4:0] letter;
  logic       other_hit, map_hit, dec_push;
  logic [6:0] other_char, dec_char;

  // letter holds alphabet position + 1 so that 0 means "not a letter".
  always_comb begin
    letter     = '0;
    other_hit  = 1'b1;
    other_char = '0;
    case (shreg_q)
      8'h1C: letter = 5'd1;   8'h32: letter = 5'd2;   8'h21: letter = 5'd3;
      8'h23: letter = 5'd4;   8'h24: letter = 5'd5;   8'h2B: letter = 5'd6;
      8'h34: letter = 5'd7;   8'h33: letter = 5'd8;   8'h43: letter = 5'd9;
      8'h3B: letter = 5'd10;  8'h42: letter = 5'd11;  8'h4B: letter = 5'd12;
      8'h3A: letter = 5'd13;  8'h31: letter = 5'd14;  8'h44: letter = 5'd15;
      8'h4D: letter = 5'd16;  8'h15: letter = 5'd17;  8'h2D: letter = 5'd18;
      8'h1B: letter = 5'd19;  8'h2C: letter = 5'd20;  8'h3C: letter = 5'd21;
      8'h2A: letter = 5'd22;  8'h1D: letter = 5'd23;  8'h22: letter = 5'd24;
      8'h35: letter = 5'd25;  8'h1A: letter = 5'd26;
      default: letter = '0;
    endcase
    case (shreg_q)
      8'h45: other_char = 7'h30;  8'h16: other_char = 7'h31;  8'h1E: other_char = 7'h32;
      8'h26: other_char = 7'h33;  8'h25: other_char = 7'h34;  8'h2E: other_char = 7'h35;
      8'h36: other_char = 7'h36;  8'h3D: other_char = 7'h37;  8'h3E: other_char = 7'h38;
      8'h46: other_char = 7'h39;  8'h29: other_char = 7'h20;  8'h5A: other_char = 7'h0D;
      8'h66: other_char = 7'h08;
      default: other_hit = 1'b0;
    endcase
  end

  assign map_hit  = (letter != '0) | other_hit;
  assign dec_char = (letter != '0) ? (((shift_q ^ caps_q) ? 7'h40 : 7'h60) + 7'(letter))
                                   : other_char;
  // Prefix codes are never in the map, so a pending prefix is the only extra gate needed.
  assign dec_push = byte_valid_q & map_hit & ~brk_q & ~ext_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
      shift_q <= 1'b0;
      caps_q  <= 1'b0;
    end else if (byte_valid_q) begin
      if (shreg_q == 8'hF0) begin
        brk_q <= 1'b1;
      end else if (shreg_q == 8'hE0) begin
        ext_q <= 1'b1;
      end else begin
        brk_q <= 1'b0;
        ext_q <= 1'b0;
        if (!ext_q) begin
          if (shreg_q == 8'h12 || shreg_q == 8'h59) shift_q <= ~brk_q;
          else if (shreg_q == 8'h58 && !brk_q)      caps_q  <= ~caps_q;
        end
      end
    end
  end

  logic [6:0]      mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            full, pop, wr_en, overflow_q;

  assign full  = (count_q == CntW'(FIFO_DEPTH));
  assign pop   = ascii_valid & ascii_ready;
  assign wr_en = dec_push & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= dec_char;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (wr_en && !pop)      count_q <= count_q + CntW'(1);
      else if (!wr_en && pop) count_q <= count_q - CntW'(1);
      overflow_q <= dec_push & full & ~pop;
    end
  end

  assign ascii_valid = (count_q != '0);
  assign ascii_data  = ascii_valid ? mem[rd_ptr_q] : '0;
  assign fifo_count  = count_q;
  assign frame_err   = frame_err_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_ascii_fifo.sv
// Bench for ps2_ascii_fifo: directed test-plan steps followed by random keystroke batches
// checked against a scancode-level reference model.
module tb_ps2_ascii_fifo;
  localparam int DEPTH = 8;
  localparam int FLT   = 8;
  localparam int TMO   = 200;
  localparam int HALF  = 20;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       ascii_ready = 1'b0;
  logic [6:0] ascii_data;
  logic       ascii_valid;
  logic [3:0] fifo_count;
  logic       frame_err, overflow;

  always #5 clk = ~clk;

  ps2_ascii_fifo #(
    .FIFO_DEPTH     (DEPTH),
    .FILTER_LEN     (FLT),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .ps2_clk     (ps2_clk),
    .ps2_dat     (ps2_dat),
    .ascii_data  (ascii_data),
    .ascii_valid (ascii_valid),
    .ascii_ready (ascii_ready),
    .fifo_count  (fifo_count),
    .frame_err   (frame_err),
    .overflow    (overflow)
  );

  int passed = 0, failed = 0, total = 0;
  int fe_cnt = 0, ov_cnt = 0;

  always @(posedge clk) begin
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    if (overflow === 1'b1)  ov_cnt <= ov_cnt + 1;
  end

  // Reference model: key tables plus make/break/shift/caps rules, FIFO as a queue.
  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                    8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                    8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                   8'h3E, 8'h46};
  logic [6:0] q_model [$];
  logic       m_shift = 1'b0, m_caps = 1'b0, m_brk = 1'b0, m_ext = 1'b0;
  int         m_ovf = 0;

  function automatic int model_char(input logic [7:0] b, input logic upper);
    for (int i = 0; i < 26; i++) if (letter_codes[i] == b) return upper ? 'h41 + i : 'h61 + i;
    for (int i = 0; i < 10; i++) if (digit_codes[i] == b) return 'h30 + i;
    if (b == 8'h29) return 32;
    if (b == 8'h5A) return 13;
    if (b == 8'h66) return 8;
    return -1;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int c;
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (m_ext) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (m_brk) begin
      if (b == 8'h12 || b == 8'h59) m_shift = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'h12 || b == 8'h59) m_shift = 1'b1;
    else if (b == 8'h58) m_caps = ~m_caps;
    else begin
      c = model_char(b, m_shift ^ m_caps);
      if (c >= 0) begin
        if (q_model.size() < DEPTH) q_model.push_back(7'(c));
        else m_ovf++;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input logic bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic ps2_bit(input logic b);
    @(negedge clk) ps2_dat = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) ps2_bit(f[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(frame(b, 1'b0), 11);
    repeat (HALF) @(negedge clk);
    model_byte(b);
  endtask

  task automatic pop_one();
    ascii_ready = 1'b1;
    @(negedge clk);
    ascii_ready = 1'b0;
    if (q_model.size() > 0) void'(q_model.pop_front());
  endtask

  task automatic drain_check(input string tag);
    check({tag, "_count"}, 32'(fifo_count), 32'(q_model.size()));
    while (q_model.size() > 0) begin
      check({tag, "_valid"}, 32'(ascii_valid), 32'd1);
      check({tag, "_data"}, 32'(ascii_data), 32'(q_model[0]));
      pop_one();
    end
    check({tag, "_empty"}, 32'(ascii_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within the cycle budget");
    $fatal(1);
  end

  initial begin
    int lat, fe0, ov0, r;
    logic [7:0] codes9 [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};

    repeat (3) @(negedge clk);
    check("rst_valid", 32'(ascii_valid), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_data", 32'(ascii_data), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_overflow", 32'(overflow), 0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    // 'a' with ready held high: one-cycle valid, fixed latency from the stop-bit clock edge.
    ascii_ready = 1'b1;
    send_bits(frame(8'h1C, 1'b0), 10);
    @(negedge clk) ps2_dat = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    lat = 0;
    while (lat < 40 && ascii_valid !== 1'b1) begin
      @(negedge clk);
      lat++;
    end
    check("t1_valid_seen", 32'(ascii_valid), 1);
    check("t1_data", 32'(ascii_data), 32'h61);
    check("t1_latency_window", 32'(lat >= FLT + 2 && lat <= FLT + 5), 1);
    @(negedge clk);
    check("t1_one_cycle", 32'(ascii_valid), 0);
    check("t1_count", 32'(fifo_count), 0);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    ascii_ready = 1'b0;
    repeat (HALF) @(negedge clk);

    // Shifted then unshifted letter.
    send_byte(8'h12); send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h12); send_byte(8'h1C);
    check("t2_count", 32'(fifo_count), 2);
    check("t2_head_A", 32'(ascii_data), 32'h41);
    pop_one();
    check("t2_second_a", 32'(ascii_data), 32'h61);
    pop_one();
    check("t2_empty", 32'(ascii_valid), 0);

    // Bad parity then a good space.
    fe0 = fe_cnt;
    send_bits(frame(8'h1C, 1'b1), 11);
    repeat (HALF) @(negedge clk);
    check("t3_parity_err", 32'(fe_cnt - fe0), 1);
    check("t3_no_push", 32'(fifo_count), 0);
    send_byte(8'h29);
    check("t3_space", 32'(ascii_data), 32'h20);
    pop_one();

    // Partial frame abandoned by timeout.
    fe0 = fe_cnt;
    send_bits(frame(8'h1C, 1'b0), 4);
    repeat (TMO + 50) @(negedge clk);
    check("t4_timeout_err", 32'(fe_cnt - fe0), 1);
    check("t4_no_push", 32'(fifo_count), 0);
    send_byte(8'h16);
    check("t4_digit1", 32'(ascii_data), 32'h31);
    pop_one();

    // Overflow, then push and pop on the same edge while full.
    ov0 = ov_cnt;
    for (int i = 0; i < 8; i++) send_byte(codes9[i]);
    check("t5_full_count", 32'(fifo_count), 8);
    check("t5_no_ovf_yet", 32'(ov_cnt - ov0), 0);
    send_byte(codes9[8]);
    check("t5_count_after_drop", 32'(fifo_count), 8);
    check("t5_one_overflow", 32'(ov_cnt - ov0), 1);
    check("t5_model_ovf", 32'(m_ovf), 1);
    send_bits(frame(8'h3B, 1'b0), 10);
    @(negedge clk) ps2_dat = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (lat - 1) @(negedge clk);
    ascii_ready = 1'b1;
    @(negedge clk);
    ascii_ready = 1'b0;
    void'(q_model.pop_front());
    model_byte(8'h3B);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    check("t5_simul_count", 32'(fifo_count), 8);
    check("t5_simul_no_ovf", 32'(ov_cnt - ov0), 1);
    check("t5_head_b", 32'(ascii_data), 32'h62);
    drain_check("t5_drain");

    // Caps lock, ignored extended code, then reset mid-frame.
    send_byte(8'h58); send_byte(8'hE0); send_byte(8'h1C); send_byte(8'h1C);
    check("t6_count", 32'(fifo_count), 1);
    check("t6_caps_A", 32'(ascii_data), 32'h41);
    send_bits(frame(8'h1C, 1'b0), 5);
    resetn = 1'b0;
    @(negedge clk);
    check("t6_rst_valid", 32'(ascii_valid), 0);
    check("t6_rst_count", 32'(fifo_count), 0);
    check("t6_rst_data", 32'(ascii_data), 0);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    q_model.delete();
    m_shift = 1'b0; m_caps = 1'b0; m_brk = 1'b0; m_ext = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    send_byte(8'h1C);
    check("t6_after_rst_a", 32'(ascii_data), 32'h61);
    drain_check("t6_drain");

    // Random keystroke batches against the model.
    for (int b = 0; b < 5; b++) begin
      ov0 = ov_cnt;
      fe0 = fe_cnt;
      m_ovf = 0;
      for (int k = 0; k < 5; k++) begin
        r = $urandom_range(0, 7);
        case (r)
          0, 1: send_byte(letter_codes[$urandom_range(0, 25)]);
          2: send_byte(digit_codes[$urandom_range(0, 9)]);
          3: send_byte(($urandom_range(0, 1) == 0) ? 8'h29 : 8'h5A);
          4: begin
            if (m_shift) send_byte(8'hF0);
            send_byte(($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59);
          end
          5: begin
            send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58);
          end
          6: begin
            send_byte(($urandom_range(0, 1) == 0) ? 8'hE0 : 8'hF0);
            send_byte(letter_codes[$urandom_range(0, 25)]);
          end
          default: send_byte(($urandom_range(0, 1) == 0) ? 8'h76 : 8'h66);
        endcase
      end
      check("rnd_overflow", 32'(ov_cnt - ov0), 32'(m_ovf));
      check("rnd_no_frame_err", 32'(fe_cnt - fe0), 0);
      drain_check("rnd_drain");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ps2_ascii_fifo.md
Name: ps2_ascii_fifo

Overview:
- Next-generation keyboard front end: PS/2 line receiver, scancode-set-2 decoder and ASCII translator with an output FIFO, all in the system clock domain.
- PS/2 clock and data are treated as asynchronous inputs. The block checks each frame, tracks make/break, shift and caps-lock state, and emits lower- or upper-case ASCII.
- Characters leave through a valid/ready stream, so the text buffer logic can drain them at its own rate.

Parameters:
- FIFO_DEPTH, 8, number of buffered ASCII characters; power of two, 2..64.
- FILTER_LEN, 8, consecutive identical clk samples required before the filtered PS/2 clock changes level.
- TIMEOUT_CYCLES, 50000, clk cycles without a filtered PS/2 falling edge before a partial frame is abandoned.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock line, asynchronous.
- ps2_dat  in  1  raw PS/2 data line, asynchronous.
- ascii_data  out  7  ASCII code at the FIFO head; valid only while ascii_valid=1.
- ascii_valid  out  1  FIFO not empty.
- ascii_ready  in  1  consumer accepts the head when ascii_valid=1.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  number of characters held.
- frame_err  out  1  one-cycle pulse when a frame is discarded (parity, stop or timeout).
- overflow  out  1  one-cycle pulse when a character is dropped because the FIFO is full.

Behaviour:
- Reset: all outputs are 0. The FSM goes to IDLE, the FIFO empties, and the shift, caps, break and extended flags clear. The filtered PS/2 clock resets to 1.
- Input conditioning:
  - ps2_clk and ps2_dat each pass through a 2-flop synchronizer.
  - The filtered clock takes a new level after FILTER_LEN consecutive equal synchronized samples.
  - A 1-to-0 transition of the filtered clock is a "fall". Data is sampled on the fall cycle.
- Receiver FSM:
  - IDLE: on a fall with dat=0, go to DATA with bitcnt=0. A fall with dat=1 is ignored (bad start) and stays in IDLE.
  - DATA: on each fall, shift in data LSB first. After the 8th bit, go to PARITY.
  - PARITY: on a fall, store the parity bit and go to STOP.
  - STOP: on a fall, the frame is good if stop=1 and the XOR of the 8 data bits plus parity is 1 (odd parity). A good frame asserts byte_valid for one cycle. Otherwise frame_err pulses. Either way, return to IDLE.
  - Timeout: in any state other than IDLE, if TIMEOUT_CYCLES pass with no fall, go to IDLE and pulse frame_err.
- Decoder (acts in the cycle byte_valid=1; break and ext are consumed by the next non-prefix byte):
  - 0xF0 sets break. 0xE0 sets ext. Neither pushes.
  - Any byte received with ext=1 is ignored, then break and ext clear.
  - 0x12 or 0x59 with break=0 sets shift. With break=1 it clears shift.
  - 0x58 with break=0 toggles caps. Its break is ignored.
  - Any other byte with break=1: no push, break clears.
  - Letters use the standard set-2 codes (A=0x1C … Z=0x1A). The output is upper case when shift XOR caps, otherwise lower case (0x61..0x7A).
  - Digit codes 0x45, 0x16..0x46 give '0'..'9' regardless of shift.
  - 0x29 gives 32 (space), 0x5A gives 13 (CR), 0x66 gives 8 (BS).
  - Unmapped make codes push nothing; there is no default character.
- Timing: a push is registered 1 cycle after byte_valid. ascii_valid/ascii_data appear the cycle after that, i.e. 2 cycles after the stop-bit fall when the FIFO was empty.
- FIFO:
  - Show-ahead, with wrap-around pointers modulo FIFO_DEPTH.
  - A pop occurs when ascii_valid & ascii_ready.
  - A push while full without a pop is dropped and pulses overflow; count stays FIFO_DEPTH.
  - A push and pop in the same cycle are both performed, whether full or not; count is unchanged.
  - ascii_ready while empty has no effect.
- Reset mid-frame or mid-stream: any partial frame, the flags and all FIFO contents are lost. After release, the first character needs a full new frame.

Test Plan:
- Frame 0x1C (parity 0), stop 1, ready=1, caps=shift=0 -> ascii_data=0x61 ('a'), ascii_valid for 1 cycle, exactly 2 cycles after the stop fall.
- Sequence 0x12, 0x1C, 0xF0 0x1C, 0xF0 0x12, 0x1C -> FIFO holds 'A' (0x41) then 'a' (0x61); fifo_count=2 with ready=0.
- Frame 0x1C with parity bit 1 -> frame_err pulse, nothing pushed. Next valid 0x29 -> 0x20.
- 3 data bits then bus idle for TIMEOUT_CYCLES -> frame_err pulse, FSM in IDLE. A following full frame 0x16 -> '1' (0x31).
- FIFO_DEPTH=8, ready=0, 9 make codes -> count=8, one overflow pulse. On the 9th push with ready=1 in the same cycle, count stays 8 and there is no overflow.
- 0x58, then 0xE0 0x1C, then 0x1C, then resetn low mid-frame -> first 'A' (0x41) only (the ext byte is ignored). After reset: valid=0, count=0, caps cleared, and 0x1C -> 0x61.
